// File: rtl/prio_arbiter.sv
// Request arbiter with a registered grant and a ready/valid handshake to the consumer.
// mode=0 picks the highest requesting index. mode=1 is round-robin: the search
// descends from just below the last handed-off index, with wrap-around.
// Optional feature: define PRIO_ARBITER_ONEHOT_EN to add a registered one-hot
// copy of the grant on port gnt_onehot.
module prio_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             mode,
    input  logic             gnt_ready,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
`ifdef PRIO_ARBITER_ONEHOT_EN
    ,
    output logic [N-1:0]     gnt_onehot
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [IDX_W-1:0] fixed_win;
    logic [IDX_W-1:0] rr_win;
    logic [IDX_W-1:0] rr_base;
    logic [IDX_W-1:0] winner;
    logic             rr_found;
    logic             handshake;

    assign handshake = (state == GRANT) && gnt_ready;

    // Winner selection for both modes. On a handshake the index being handed
    // off becomes the last-served one, so the search bases on it directly.
    always_comb begin
        fixed_win = '0;
        rr_win    = '0;
        rr_found  = 1'b0;
        rr_base   = handshake ? gnt_idx : ptr;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i]) begin
                fixed_win = IDX_W'(i);
            end
        end
        for (int unsigned k = 0; k < N; k++) begin
            if (!rr_found && req[(32'(rr_base) + 2 * N - 1 - k) % N]) begin
                rr_win   = IDX_W'((32'(rr_base) + 2 * N - 1 - k) % N);
                rr_found = 1'b1;
            end
        end
        winner = mode ? rr_win : fixed_win;
    end

    // Next-state logic: arbitrate when idle or on a handshake, otherwise hold.
    always_comb begin
        state_nxt = state;
        idx_nxt   = gnt_idx;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = GRANT;
                    idx_nxt   = winner;
                end
            end
            GRANT: begin
                if (gnt_ready) begin
                    ptr_nxt = gnt_idx;
                    if (|req) begin
                        idx_nxt = winner;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, pointer and registered grant outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt_idx    <= '0;
            gnt_valid  <= 1'b0;
            ptr        <= '0;
`ifdef PRIO_ARBITER_ONEHOT_EN
            gnt_onehot <= '0;
`endif
        end else begin
            state      <= state_nxt;
            gnt_idx    <= idx_nxt;
            gnt_valid  <= (state_nxt == GRANT);
            ptr        <= ptr_nxt;
`ifdef PRIO_ARBITER_ONEHOT_EN
            gnt_onehot <= (state_nxt == GRANT) ? (N'(1) << idx_nxt) : '0;
`endif
        end
    end

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed bench for prio_arbiter (N=4) with hand-computed expected grants.
module tb_prio_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned IDX_W = 2;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req;
    logic             mode;
    logic             gnt_ready;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
`ifdef PRIO_ARBITER_ONEHOT_EN
    logic [N-1:0]     gnt_onehot;
`endif

    int vectors     = 0;
    int miscompares = 0;

    prio_arbiter #(.N(N), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mode      (mode),
        .gnt_ready (gnt_ready),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
`ifdef PRIO_ARBITER_ONEHOT_EN
        ,
        .gnt_onehot(gnt_onehot)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        req       = '0;
        mode      = 1'b0;
        gnt_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req       = 4'b1111;
        mode      = 1'b0;
        gnt_ready = 1'b1;
        for (int e = 0; e < 2; e++) begin
            step();
            vectors++;
            if (gnt_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_valid edge %0d: got %b want 0", e, gnt_valid);
            end
            vectors++;
            if (gnt_idx !== 2'd0) begin
                miscompares++;
                $display("FAIL reset_idx edge %0d: got %0d want 0", e, gnt_idx);
            end
`ifdef PRIO_ARBITER_ONEHOT_EN
            vectors++;
            if (gnt_onehot !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_onehot edge %0d: got %b want 0000", e, gnt_onehot);
            end
`endif
        end
    endtask

    task automatic test_fixed;
        logic [3:0] reqs [6];
        logic [1:0] exps [6];
        reqs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1101, 4'b1010};
        exps = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        mode      = 1'b0;
        gnt_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req = reqs[i];
            step();
            vectors++;
            if (gnt_valid !== 1'b1 || gnt_idx !== exps[i]) begin
                miscompares++;
                $display("FAIL fixed[%0d] req=%b: got valid=%b idx=%0d want valid=1 idx=%0d",
                         i, reqs[i], gnt_valid, gnt_idx, exps[i]);
            end
`ifdef PRIO_ARBITER_ONEHOT_EN
            vectors++;
            if (gnt_onehot !== (4'b0001 << exps[i])) begin
                miscompares++;
                $display("FAIL fixed_onehot[%0d]: got %b want %b", i, gnt_onehot, 4'b0001 << exps[i]);
            end
`endif
        end
        req = 4'b0000;
        for (int e = 0; e < 2; e++) begin
            step();
            vectors++;
            if (gnt_valid !== 1'b0 || gnt_idx !== 2'd3) begin
                miscompares++;
                $display("FAIL fixed_idle edge %0d: got valid=%b idx=%0d want valid=0 idx=3",
                         e, gnt_valid, gnt_idx);
            end
        end
`ifdef PRIO_ARBITER_ONEHOT_EN
        vectors++;
        if (gnt_onehot !== 4'b0000) begin
            miscompares++;
            $display("FAIL fixed_idle_onehot: got %b want 0000", gnt_onehot);
        end
`endif
    endtask

    task automatic test_round_robin;
        logic [1:0] exps [6];
        exps = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2};
        do_reset();
        mode      = 1'b1;
        gnt_ready = 1'b1;
        req       = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++;
            if (gnt_valid !== 1'b1 || gnt_idx !== exps[i]) begin
                miscompares++;
                $display("FAIL rr[%0d]: got valid=%b idx=%0d want valid=1 idx=%0d",
                         i, gnt_valid, gnt_idx, exps[i]);
            end
        end
    endtask

    task automatic test_hold;
        logic [3:0] reqs [3];
        reqs = '{4'b0100, 4'b0001, 4'b0000};
        do_reset();
        mode      = 1'b1;
        gnt_ready = 1'b0;
        req       = 4'b0100;
        step();
        vectors++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 2'd2) begin
            miscompares++;
            $display("FAIL hold_first: got valid=%b idx=%0d want valid=1 idx=2", gnt_valid, gnt_idx);
        end
        for (int i = 0; i < 3; i++) begin
            req  = reqs[i];
            mode = (i == 1) ? 1'b0 : 1'b1;
            step();
            vectors++;
            if (gnt_valid !== 1'b1 || gnt_idx !== 2'd2) begin
                miscompares++;
                $display("FAIL hold[%0d] req=%b: got valid=%b idx=%0d want valid=1 idx=2",
                         i, reqs[i], gnt_valid, gnt_idx);
            end
        end
        mode      = 1'b1;
        gnt_ready = 1'b1;
        req       = 4'b0000;
        step();
        vectors++;
        if (gnt_valid !== 1'b0 || gnt_idx !== 2'd2) begin
            miscompares++;
            $display("FAIL hold_release: got valid=%b idx=%0d want valid=0 idx=2", gnt_valid, gnt_idx);
        end
        // ptr is now 2, so a full request vector should pick 1 first.
        req = 4'b1111;
        step();
        vectors++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 2'd1) begin
            miscompares++;
            $display("FAIL hold_ptr: got valid=%b idx=%0d want valid=1 idx=1", gnt_valid, gnt_idx);
        end
    endtask

    task automatic test_sole_requester;
        logic [3:0] reqs [4];
        logic [1:0] exps [4];
        reqs = '{4'b0001, 4'b0001, 4'b1001, 4'b1001};
        exps = '{2'd0, 2'd0, 2'd3, 2'd0};
        do_reset();
        mode      = 1'b1;
        gnt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req = reqs[i];
            step();
            vectors++;
            if (gnt_valid !== 1'b1 || gnt_idx !== exps[i]) begin
                miscompares++;
                $display("FAIL sole[%0d] req=%b: got valid=%b idx=%0d want valid=1 idx=%0d",
                         i, reqs[i], gnt_valid, gnt_idx, exps[i]);
            end
        end
    endtask

    task automatic test_reset_mid_grant;
        do_reset();
        mode      = 1'b1;
        gnt_ready = 1'b0;
        req       = 4'b0010;
        step();
        vectors++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 2'd1) begin
            miscompares++;
            $display("FAIL mid_grant: got valid=%b idx=%0d want valid=1 idx=1", gnt_valid, gnt_idx);
        end
        rst_n = 1'b0;
        step();
        vectors++;
        if (gnt_valid !== 1'b0 || gnt_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got valid=%b idx=%0d want valid=0 idx=0", gnt_valid, gnt_idx);
        end
        rst_n     = 1'b1;
        gnt_ready = 1'b1;
        req       = 4'b0011;
        step();
        vectors++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 2'd1) begin
            miscompares++;
            $display("FAIL mid_rearb: got valid=%b idx=%0d want valid=1 idx=1", gnt_valid, gnt_idx);
        end
`ifdef PRIO_ARBITER_ONEHOT_EN
        vectors++;
        if (gnt_onehot !== 4'b0010) begin
            miscompares++;
            $display("FAIL mid_onehot: got %b want 0010", gnt_onehot);
        end
`endif
        // Served 1 with 0 still requesting: 0 is next.
        step();
        vectors++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL mid_next: got valid=%b idx=%0d want valid=1 idx=0", gnt_valid, gnt_idx);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        mode      = 1'b0;
        gnt_ready = 1'b0;
        test_reset();
        test_fixed();
        test_round_robin();
        test_hold();
        test_sole_requester();
        test_reset_mid_grant();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prio_arbiter.md
PRIO_ARBITER -- requirements
Module: prio_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, number of request lines (2..32).
REQ-002 The block SHALL have parameter IDX_W, default 2, grant index width (SHALL equal ceil(log2(N)); N=2 gives 1).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port req  input  N  request vector; bit i = requester i.
REQ-006 The block SHALL have port mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
REQ-007 The block SHALL have port gnt_ready  input  1  consumer accepts the current grant.
REQ-008 The block SHALL have port gnt_idx  output  IDX_W  index of the granted requester, registered.
REQ-009 The block SHALL have port gnt_valid  output  1  gnt_idx holds a valid grant, registered.

Function
REQ-010 The block SHALL implement two states: IDLE (gnt_valid=0) and GRANT (gnt_valid=1).
REQ-011 In IDLE with req!=0 at edge t, the block SHALL enter GRANT, with gnt_valid=1 and gnt_idx=winner visible after edge t (1-cycle latency).
REQ-012 In IDLE with req==0, the block SHALL stay in IDLE and SHALL hold gnt_idx at its last value.
REQ-013 In GRANT with gnt_ready=0, the block SHALL hold gnt_idx and gnt_valid stable, even if req changes or the granted bit drops.
REQ-014 In GRANT with gnt_ready=1 (handshake), the block SHALL re-arbitrate on the same edge: if req!=0, it SHALL stay in GRANT with the new winner (back-to-back, no bubble); else it SHALL go to IDLE.
REQ-015 With mode=0, the winner SHALL be the highest set index of req.
REQ-016 With mode=1, the search SHALL start at index (ptr-1) mod N and descend with wrap-around, where ptr = last handed-off index; the first set bit SHALL win.
REQ-017 ptr SHALL update to gnt_idx only on a handshake, regardless of mode.
REQ-018 The just-served requester SHALL have lowest priority in mode=1, and SHALL still win if it is the only request.
REQ-019 mode SHALL be sampled only at arbitration edges; a change mid-GRANT SHALL NOT affect the held grant.
REQ-020 Wrap-around SHALL be exact: with ptr=0 in mode=1, the search SHALL begin at N-1.

Reset
REQ-021 On a rising clk edge with rst_n=0, the block SHALL set state=IDLE, gnt_valid=0, gnt_idx=0, and ptr=0.
REQ-022 Reset mid-GRANT SHALL drop the grant without a handshake, and ptr SHALL NOT retain the dropped index.
REQ-023 On the first edge with rst_n=1, the block SHALL arbitrate normally; with ptr=0, the first round-robin search SHALL start at N-1.

Configuration
REQ-024 When macro PRIO_ARBITER_ONEHOT_EN is defined, the block SHALL add output port gnt_onehot, width N, registered, equal to (1<<gnt_idx) when gnt_valid=1 and all-zero otherwise, with reset value 0.
REQ-025 When PRIO_ARBITER_ONEHOT_EN is undefined, port gnt_onehot and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification (N=4)
REQ-026 Scenario: rst_n=0 for 2 edges, req=4'b1111 -> gnt_valid=0 and gnt_idx=0 throughout reset.
REQ-027 Scenario: mode=0, gnt_ready=1, req 0001,0010,0100,1000,1101,1010 on successive edges -> gnt_idx 0,1,2,3,3,3 with gnt_valid=1; then req=0000 -> gnt_valid=0 next edge.
REQ-028 Scenario: mode=1, req=1111 held, gnt_ready=1 -> gnt_idx sequence 3,2,1,0,3,2 with no gnt_valid gap.
REQ-029 Scenario: mode=1, grant of 2 pending, gnt_ready=0 for 3 edges while req changes 0100->0001->0000 -> gnt_idx stays 2; then gnt_ready=1 with req=0000 -> IDLE.
REQ-030 Scenario: mode=1 after serving 0, req=0001 only -> gnt_idx=0 (sole requester); then req=1001 after handshake -> gnt_idx=3.
REQ-031 Scenario: rst_n=0 pulsed mid-GRANT (idx 1, mode=1), then req=0011 -> gnt_valid=0 for one edge, then gnt_idx=1 (search from 3 because ptr=0); with PRIO_ARBITER_ONEHOT_EN, gnt_onehot=0010.
